// File: rtl/fp16_pkg.sv
// Shared constants and stage payload type for the fp16 multiply round/pack stage.
package fp16_pkg;

   localparam int unsigned EXP_W = 5;
   localparam int unsigned MAN_W = 10;
   localparam int unsigned BIAS  = 15;

   localparam int unsigned NV = 3;
   localparam int unsigned OF = 2;
   localparam int unsigned UF = 1;
   localparam int unsigned NX = 0;

   localparam logic [15:0] QNAN = 16'h7E00;
   localparam logic [15:0] PINF = 16'h7C00;

   // exp holds (biased exponent - 1) for normals and 0 for subnormals,
   // so packing becomes a single add of the 11-bit significand.
   typedef struct packed {
      logic        sign;
      logic [8:0]  exp;
      logic [10:0] sig11;
      logic        g;
      logic        r;
      logic        s;
      logic        tiny;
      logic        special;
      logic [15:0] special_res;
      logic [3:0]  flags;
   } s1_payload_t;

endpackage

// File: rtl/fp16_mul_round_stage_lzc22.sv
// Combinational 22-bit leading-zero counter; a zero input yields 22.
module lzc22 (
   input  logic [21:0] value,
   output logic [4:0]  count
);

   always_comb begin
      count = 5'd22;
      for (int unsigned i = 0; i < 22; i++) begin
         if (value[i]) count = 5'(21 - i);
      end
   end

endmodule

// File: rtl/fp16_mul_round_stage.sv
// Two-stage normalize / round-to-nearest-even / pack stage for fp16 products,
// with valid/ready on both sides and a sticky exception-flag register.
module fp16_mul_round_stage #(
   parameter int unsigned EXP_W = fp16_pkg::EXP_W,
   parameter int unsigned MAN_W = fp16_pkg::MAN_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [7:0]             in_exp,
   input  logic [21:0]            in_sig,
   input  logic                   in_special_valid,
   input  logic [EXP_W+MAN_W:0]   in_special,
   input  logic                   in_special_nv,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic [3:0]             out_flags,
   output logic [3:0]             fflags,
   input  logic                   fflags_clr
);

   import fp16_pkg::*;

   logic        s1_valid, s2_valid;
   logic        s1_ready, s2_ready;
   s1_payload_t s1_d, s1_q;

   logic [4:0]        lzc;
   logic [21:0]       sig_n;
   logic signed [8:0] e9, sh_full;
   logic [4:0]        sh;
   logic [45:0]       ext;
   logic              tiny;

   logic        inc, ovf, nx;
   logic [19:0] mag;
   logic [15:0] res_d;
   logic [3:0]  flags_d;

   assign s2_ready  = ~s2_valid | out_ready;
   assign s1_ready  = ~s1_valid | s2_ready;
   assign in_ready  = s1_ready;
   assign out_valid = s2_valid;

   lzc22 u_lzc (
      .value (in_sig),
      .count (lzc)
   );

   // S1: normalize so the leading one sits at bit 21, denormalize below 2^-14.
   always_comb begin
      sig_n   = in_sig << lzc;
      e9      = $signed({in_exp[7], in_exp}) + 9'sd1 - $signed({4'b0, lzc});
      tiny    = e9 < -9'sd14;
      sh_full = -9'sd14 - e9;
      sh      = '0;
      if (tiny) sh = (sh_full > 9'sd24) ? 5'd24 : sh_full[4:0];
      ext     = {sig_n, 24'b0} >> sh;

      s1_d             = '0;
      s1_d.sign        = in_sign;
      s1_d.special     = in_special_valid;
      s1_d.special_res = in_special;
      s1_d.flags[NV]   = in_special_valid & in_special_nv;
      if (!in_special_valid && in_sig != '0) begin
         s1_d.exp   = tiny ? '0 : 9'(e9 + 9'(BIAS - 1));
         s1_d.sig11 = ext[45:35];
         s1_d.g     = ext[34];
         s1_d.r     = ext[33];
         s1_d.s     = |ext[32:0];
         s1_d.tiny  = tiny;
      end
   end

   // S2: RNE increment; carries ripple naturally into the exponent field.
   always_comb begin
      inc = s1_q.g & (s1_q.r | s1_q.s | s1_q.sig11[0]);
      mag = {1'b0, s1_q.exp, 10'b0} + {9'b0, s1_q.sig11} + {19'b0, inc};
      ovf = mag >= 20'h07C00;
      nx  = s1_q.g | s1_q.r | s1_q.s;

      res_d   = {s1_q.sign, mag[14:0]};
      flags_d = '0;
      if (s1_q.special) begin
         res_d   = s1_q.special_res;
         flags_d = s1_q.flags;
      end else if (ovf) begin
         res_d       = {s1_q.sign, PINF[14:0]};
         flags_d[OF] = 1'b1;
         flags_d[NX] = 1'b1;
      end else begin
         flags_d[UF] = s1_q.tiny & nx;
         flags_d[NX] = nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         fflags     <= '0;
      end else begin
         if (s1_ready) s1_valid <= in_valid;
         if (s2_ready) s2_valid <= s1_valid;
         if (s2_ready && s1_valid) begin
            out_result <= res_d;
            out_flags  <= flags_d;
         end
         fflags <= (fflags_clr ? 4'b0 : fflags) | ((out_valid && out_ready) ? out_flags : 4'b0);
      end
   end

   always_ff @(posedge clk) begin
      if (s1_ready && in_valid) s1_q <= s1_d;
   end

endmodule

// File: tb/tb_fp16_mul_round_stage.sv
// Self-checking bench: directed cases plus randomized traffic against an exact-arithmetic fp16 model.
module tb_fp16_mul_round_stage;

   import fp16_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [21:0] in_sig;
   logic        in_special_valid;
   logic [15:0] in_special;
   logic        in_special_nv;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_result;
   logic [3:0]  out_flags;
   logic [3:0]  fflags;
   logic        fflags_clr;

   int n_checks = 0;
   int n_fail   = 0;
   int ready_mode = 1;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  fl;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   fp16_mul_round_stage #(.EXP_W(5), .MAN_W(10)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_sign          (in_sign),
      .in_exp           (in_exp),
      .in_sig           (in_sig),
      .in_special_valid (in_special_valid),
      .in_special       (in_special),
      .in_special_nv    (in_special_nv),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_flags        (out_flags),
      .fflags           (fflags),
      .fflags_clr       (fflags_clr)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Exact value sig * 2^(e-20), quantized to the fp16 grid with round-half-even.
   function automatic void ref_fp(input bit sign, input int e_in, input int sig,
                                  input bit sv, input logic [15:0] sp, input bit nv,
                                  output logic [15:0] res, output logic [3:0] fl);
      int msb, eu, q, k, biased;
      longint m, dv, rem, half;
      bit nx, tiny;
      if (sv) begin
         res = sp;
         fl  = {nv, 3'b000};
         return;
      end
      if (sig == 0) begin
         res = {sign, 15'b0};
         fl  = 4'b0;
         return;
      end
      msb = 0;
      for (int i = 0; i < 22; i++) if (((sig >> i) & 1) != 0) msb = i;
      eu   = msb - 20 + e_in;
      tiny = eu < -14;
      q    = (tiny ? -14 : eu) - 10;
      k    = e_in - 20 - q;
      nx   = 1'b0;
      if (k >= 0) begin
         m = longint'(sig) <<< k;
      end else if (-k > 40) begin
         m  = 0;
         nx = 1'b1;
      end else begin
         dv   = longint'(1) <<< (-k);
         m    = longint'(sig) / dv;
         rem  = longint'(sig) % dv;
         half = dv / 2;
         nx   = rem != 0;
         if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
      end
      if (m == 2048) begin
         m = 1024;
         q = q + 1;
      end
      fl = {2'b00, tiny & nx, nx};
      if (m >= 1024) begin
         biased = q + 10 + 15;
         if (biased >= 31) begin
            res = {sign, PINF[14:0]};
            fl  = 4'b0101;
         end else begin
            res = {sign, 5'(biased), 10'(m - 1024)};
         end
      end else begin
         res = {sign, 5'b0, 10'(m)};
      end
   endfunction

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that commits them.
   exp_t        mon_e;
   logic [3:0]  mon_acc;
   logic [3:0]  model_f = 4'b0;
   bit          held = 1'b0;
   logic [15:0] held_res;
   logic [3:0]  held_fl;
   logic [15:0] r_res;
   logic [3:0]  r_fl;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         model_f = 4'b0;
         held    = 1'b0;
      end else begin
         chk("fflags", {12'b0, fflags}, {12'b0, model_f});
         if (held) begin
            chk("hold_valid", {15'b0, out_valid}, 16'd1);
            chk("hold_result", out_result, held_res);
            chk("hold_flags", {12'b0, out_flags}, {12'b0, held_fl});
         end
         mon_acc = 4'b0;
         if (out_valid && out_ready) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL unexpected_output: observed result %h expected no output", out_result);
            end
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("result", out_result, mon_e.res);
               chk("flags", {12'b0, out_flags}, {12'b0, mon_e.fl});
               mon_acc = mon_e.fl;
            end
         end
         model_f  = (fflags_clr ? 4'b0 : model_f) | mon_acc;
         held     = out_valid && !out_ready;
         held_res = out_result;
         held_fl  = out_flags;
         if (in_valid && in_ready) begin
            ref_fp(in_sign, int'($signed(in_exp)), int'(in_sig), in_special_valid,
                   in_special, in_special_nv, r_res, r_fl);
            mon_e.res = r_res;
            mon_e.fl  = r_fl;
            exp_q.push_back(mon_e);
         end
      end
   end

   task automatic set_in(input bit sign, input int e, input int sig,
                         input bit sv, input logic [15:0] sp, input bit nv);
      in_valid         = 1'b1;
      in_sign          = sign;
      in_exp           = 8'(e);
      in_sig           = 22'(sig);
      in_special_valid = sv;
      in_special       = sp;
      in_special_nv    = nv;
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      n_checks++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL accept_timeout: observed in_ready=0 expected 1 within 200 cycles");
      end
   endtask

   task automatic send(input bit sign, input int e, input int sig,
                       input bit sv, input logic [15:0] sp, input bit nv);
      set_in(sign, e, sig, sv, sp, nv);
      wait_accept();
   endtask

   task automatic idle();
      in_valid         = 1'b0;
      in_special_valid = 1'b0;
   endtask

   task automatic check_one(input string tag, input bit sign, input int e, input int sig,
                            input logic [15:0] res, input logic [3:0] fl);
      ready_mode = 1;
      send(sign, e, sig, 1'b0, 16'h0, 1'b0);
      idle();
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, {15'b0, out_valid}, 16'd1);
      chk({tag, "_result"}, out_result, res);
      chk({tag, "_flags"}, {12'b0, out_flags}, {12'b0, fl});
   endtask

   initial begin
      logic [15:0] sp_tab [5];
      int a, b, sig, e, pick;
      sp_tab[0] = QNAN;
      sp_tab[1] = PINF;
      sp_tab[2] = 16'hFC00;
      sp_tab[3] = 16'h0000;
      sp_tab[4] = 16'h8000;

      rst_n = 1'b0;
      fflags_clr = 1'b0;
      set_in(1'b0, 0, 0, 1'b0, 16'h0, 1'b0);
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
      chk("rst_in_ready", {15'b0, in_ready}, 16'd1);
      chk("rst_out_result", out_result, 16'h0000);
      chk("rst_out_flags", {12'b0, out_flags}, 16'd0);
      chk("rst_fflags", {12'b0, fflags}, 16'd0);
      rst_n = 1'b1;

      // Two-cycle latency on a single 1.0 product
      send(1'b0, 0, 22'h100000, 1'b0, 16'h0, 1'b0);
      idle();
      chk("lat1_valid", {15'b0, out_valid}, 16'd0);
      @(posedge clk);
      #1;
      chk("lat2_valid", {15'b0, out_valid}, 16'd1);
      chk("lat2_result", out_result, 16'h3C00);
      chk("lat2_flags", {12'b0, out_flags}, 16'd0);

      check_one("mul_1p5", 1'b0, 0, 22'h240000, 16'h4080, 4'b0000);
      check_one("inexact", 1'b0, 0, 22'h100801, 16'h3C02, 4'b0001);
      check_one("tie_even", 1'b0, 0, 22'h100200, 16'h3C00, 4'b0001);
      check_one("tie_odd", 1'b0, 0, 22'h100600, 16'h3C02, 4'b0001);
      check_one("overflow", 1'b0, 16, 22'h100000, 16'h7C00, 4'b0101);
      check_one("ovf_neg", 1'b1, 16, 22'h100000, 16'hFC00, 4'b0101);
      check_one("sub_exact", 1'b0, -15, 22'h100000, 16'h0200, 4'b0000);
      check_one("sub_to_zero", 1'b0, -26, 22'h180000, 16'h0000, 4'b0011);
      check_one("sub_to_norm", 1'b0, -15, 22'h1FFFFF, 16'h0400, 4'b0011);
      check_one("signed_zero", 1'b1, 20, 22'h000000, 16'h8000, 4'b0000);

      @(posedge clk);
      #1;
      fflags_clr = 1'b1;
      @(posedge clk);
      #1;
      fflags_clr = 1'b0;
      chk("clr_fflags", {12'b0, fflags}, 16'd0);

      // Special NaN result, then a clear coinciding with an accepted NX result
      send(1'b0, 0, 0, 1'b1, QNAN, 1'b1);
      send(1'b0, 0, 22'h100801, 1'b0, 16'h0, 1'b0);
      idle();
      chk("spec_valid", {15'b0, out_valid}, 16'd1);
      chk("spec_result", out_result, QNAN);
      chk("spec_flags", {12'b0, out_flags}, 16'h0008);
      @(posedge clk);
      #1;
      chk("fflags_nv", {12'b0, fflags}, 16'h0008);
      fflags_clr = 1'b1;
      @(posedge clk);
      #1;
      fflags_clr = 1'b0;
      chk("fflags_clr_acc", {12'b0, fflags}, 16'h0001);

      // Backpressure: two items fill the pipe, the third waits
      ready_mode = 0;
      send(1'b0, 0, 22'h100000, 1'b0, 16'h0, 1'b0);
      send(1'b0, 0, 22'h240000, 1'b0, 16'h0, 1'b0);
      set_in(1'b0, 0, 22'h100801, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {15'b0, in_ready}, 16'd0);
         chk("bp_out_valid", {15'b0, out_valid}, 16'd1);
         chk("bp_out_result", out_result, 16'h3C00);
      end
      @(posedge clk);
      #1;
      ready_mode = 1;
      wait_accept();
      chk("bp_rel_b", out_result, 16'h4080);
      send(1'b1, -15, 22'h100000, 1'b0, 16'h0, 1'b0);
      idle();
      chk("bp_rel_c", out_result, 16'h3C02);
      @(posedge clk);
      #1;
      chk("bp_rel_d", out_result, 16'h8200);
      chk("bp_rel_d_valid", {15'b0, out_valid}, 16'd1);
      @(posedge clk);
      #1;

      // Reset with two items in flight
      ready_mode = 0;
      send(1'b0, 3, 22'h155555, 1'b0, 16'h0, 1'b0);
      send(1'b0, 0, 22'h100801, 1'b0, 16'h0, 1'b0);
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst2_out_valid", {15'b0, out_valid}, 16'd0);
      chk("rst2_fflags", {12'b0, fflags}, 16'd0);
      chk("rst2_in_ready", {15'b0, in_ready}, 16'd1);
      ready_mode = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst2_no_stale", {15'b0, out_valid}, 16'd0);
      end

      // Randomized traffic with random backpressure and sticky clears
      @(posedge clk);
      #1;
      ready_mode = 2;
      for (int n = 0; n < 400; n++) begin
         fflags_clr = ($urandom_range(0, 7) == 0);
         pick = $urandom_range(0, 15);
         a = $urandom_range(0, 2047);
         b = $urandom_range(0, 2047);
         if ($urandom_range(0, 3) != 0) a = a | 1024;
         if ($urandom_range(0, 3) != 0) b = b | 1024;
         if (pick == 0) a = 0;
         sig = a * b;
         e = (pick == 1) ? $urandom_range(0, 255) - 128 : $urandom_range(0, 70) - 45;
         if (pick == 2)
            send($urandom_range(0, 1) == 1, e, sig, 1'b1, sp_tab[$urandom_range(0, 4)],
                 $urandom_range(0, 1) == 1);
         else
            send($urandom_range(0, 1) == 1, e, sig, 1'b0, 16'h0, 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
         end
      end
      idle();
      fflags_clr = 1'b0;
      ready_mode = 1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_empty", 16'(exp_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp16_mul_round_stage.md
Name: fp16_mul_round_stage

Overview:
Pipelined normalize/round/pack stage placed directly downstream of the fp16 multiplier datapath. It consumes the multiplier's raw sign, unbiased exponent sum and 22-bit significand product, plus a pre-resolved special-case result. It emits a packed IEEE binary16 result using round-to-nearest-even and per-result exception flags, and keeps a sticky fflags register. Two register stages, one result per cycle, valid/ready on both sides.

Parameters:
EXP_W, 5, exponent field width; only the default is supported and verified.
MAN_W, 10, fraction field width; only the default is supported and verified.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream product valid
in_ready  out  1  stage can accept; transfer when in_valid & in_ready
in_sign  in  1  product sign
in_exp  in  8  signed unbiased exp_a+exp_b; subnormal operands enter as -14 with leading bit 0
in_sig  in  22  raw product of two 11-bit significands; binary point between bits 20 and 19
in_special_valid  in  1  upstream already resolved result (NaN/inf/zero)
in_special  in  16  resolved result; used only when in_special_valid=1
in_special_nv  in  1  invalid-operation flag for the special result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  16  packed binary16 result
out_flags  out  4  {NV,OF,UF,NX} for out_result
fflags  out  4  sticky {NV,OF,UF,NX}
fflags_clr  in  1  clear sticky flags

Behaviour:
- Reset (rst_n=0 at posedge): s1/s2 valid=0, out_result=0, out_flags=0, fflags=0, in_ready=1. In-flight items are dropped. No other state is cleared.
- Handshake: a stage register loads when it is empty or its contents advance in the same cycle. in_ready = ~s1_valid | (~s2_valid | out_ready). The ready chain is combinational; in_ready does not depend on in_valid.
- Data and out_valid are stable while out_valid & ~out_ready. Order is preserved and no item is lost or duplicated.
- Latency: 2 cycles from input handshake to out_valid when unstalled; throughput 1 per cycle.
- S1 (normalize):
  - If in_sig==0 and in_special_valid=0, the result is signed zero with no flags.
  - Otherwise, leading-zero count on in_sig. Left-shift so the MSB lands at bit 21.
  - e = in_exp + 1 - lzc, in 9-bit signed arithmetic.
  - If e < -14, right-shift the significand by (-14 - e), saturated at 24. Shifted-out bits are OR'd into sticky. A tiny flag is set (tininess detected before rounding).
  - Keep 11 significand bits, guard, round and sticky.
- S2 (round/pack):
  - RNE: increment when guard & (round | sticky | lsb).
  - Mantissa carry-out increments the exponent. A subnormal that rounds up to 2^-14 becomes normal 0x0400.
  - Biased exponent >= 31 after rounding: result {sign,0x7C00}, flags OF|NX.
  - NX = guard|round|sticky. UF = tiny & NX.
- Special path: when in_special_valid=1, in_special passes through both stages unchanged. out_flags={in_special_nv,0,0,0}. in_sig and in_exp are ignored.
- Sticky flags: on each cycle, fflags_next = (fflags_clr ? 0 : fflags) | (out_valid & out_ready ? out_flags : 0). A clear and an accumulate in the same cycle leave only the newly accepted flags.

Decomposition:
- Shared package fp16_pkg:
  - EXP_W, MAN_W, BIAS=15
  - flag bit indices NV=3, OF=2, UF=1, NX=0
  - constants QNAN=16'h7E00, PINF=16'h7C00
  - a typedef for the S1→S2 payload struct {sign, exp, sig11, g, r, s, tiny, special, flags}
- One sub-module, lzc22: combinational 22-bit leading-zero counter, 5-bit output, returns 22 for zero input.

Test Plan:
- in_exp=0, in_sig=22'h100000, out_ready=1 → 2 cycles later out_result=16'h3C00, out_flags=0.
- in_exp=0, in_sig=22'h240000 (1.5×1.5) → out_result=16'h4080, out_flags=0. in_sig=22'h100801 → 16'h3C02, out_flags=NX.
- in_exp=16, in_sig=22'h100000 → 16'h7C00, out_flags=OF|NX. in_exp=-15, in_sig=22'h100000 → 16'h0200, out_flags=0 (exact subnormal, no UF). in_exp=-26, in_sig=22'h180000 → 16'h0000, flags UF|NX.
- in_special_valid=1, in_special=16'h7E00, in_special_nv=1 → out_result=16'h7E00, out_flags=NV, fflags=4'b1000. Next cycle fflags_clr=1 with an accepted NX result → fflags=4'b0001.
- Backpressure: stream 4 items with out_ready=0 for 5 cycles → in_ready falls after 2 accepted, outputs held stable. Release → 4 results emerge in order, one per cycle.
- Assert rst_n=0 for 1 cycle with 2 items in flight → out_valid=0 and fflags=0 next cycle; no stale result emerges afterwards.
